gpc1406_arb: RTL and testbench
==============================

# gpc1406_arb

Round-robin arbiter and output stage that shares one `gpc1406_5` generalized parallel counter among `NREQ` requesters. Each requester presents one 11-bit operand bundle:
- `src0`: 6 bits of weight 1.
- `src2`: 4 bits of weight 4.
- `src3`: 1 bit of weight 8.

The block grants one requester per cycle and drives that bundle into the shared counter. It registers the 5-bit sum together with the requester ID, behind a valid/ready handshake. It sits between the partial-product column producers and the compressor-tree accumulation stage.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID.

- `clk`  in  1: the only clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: bit i means requester i presents a bundle.
- `req_ready`  out  NREQ: one-hot grant; bit i means bundle i is accepted this cycle.
- `req_src0`  in  6*NREQ: weight-1 bits; slice i is bits [6i+5:6i].
- `req_src2`  in  4*NREQ: weight-4 bits; slice i is bits [4i+3:4i].
- `req_src3`  in  NREQ: weight-8 bit of requester i.
- `out_valid`  out  1: the registered result is valid.
- `out_ready`  in  1: the consumer accepts the result.
- `out_sum`  out  5: registered sum, 0..30.
- `out_id`  out  IDW: index of the requester that produced `out_sum`.
- `err`  out  1: sticky self-check error flag (see Configuration).

## Operation
- **Shared counter.** Exactly one `gpc1406_5` instance. Its inputs are driven through a NREQ:1 mux selected by the grant.
- **Round-robin pointer.** `ptr` (IDW bits) is the highest-priority index. The search order is `ptr`, `ptr+1`, … mod NREQ.
- **Grant condition.** A grant occurs only when both hold:
  - at least one `req_valid` bit is high, and
  - the output stage can accept, i.e. `!out_valid || out_ready`.
- **Grant outputs.** `req_ready` is combinational and one-hot or zero. It is never high for a requester whose `req_valid` is low.
- **On a grant to index g at an edge:**
  - `out_sum` ← counter result for bundle g.
  - `out_id` ← g.
  - `out_valid` ← 1.
  - `ptr` ← (g+1) mod NREQ.
- **No grant.** `ptr` is unchanged. If `out_valid && out_ready`, then `out_valid` ← 0.
- **Stall.** While `out_valid && !out_ready`, `out_sum` and `out_id` hold stable and all `req_ready` bits are 0.
- **Accept and drain in the same cycle.** This is legal: the output register is overwritten and `out_valid` stays 1. Full throughput is one result per cycle.
- **Arithmetic.** The sum is popcount(src0) + 4·popcount(src2) + 8·src3. The maximum is 6+16+8 = 30, so the result always fits 5 bits with no overflow.
- **Requester side.** A requester holds its bundle and `req_valid` until it sees `req_ready`. The arbiter never drops or duplicates a bundle.

## Timing
- **Reset values.** Asserting `rst` clears, without waiting for a clock edge:
  - `out_valid`, `out_sum`, `out_id`, `err` → 0.
  - `ptr` → 0.
  - `req_ready` → 0, because `req_valid` is ignored while `rst` is high.
- **Latency.** Exactly 1 cycle: a bundle accepted at edge k appears on `out_sum`/`out_id` with `out_valid` = 1 after edge k.
- **Reset mid-operation.** Any result held in the output register is discarded. Bundles granted in the same cycle that reset asserts are lost, and requesters re-present them.
- **Priority after reset.** Index 0 has the highest priority. With all requesters continuously valid and no backpressure, grants cycle 0,1,…,NREQ-1,0,… on consecutive edges.
- **Single active requester.** It is granted every cycle, regardless of `ptr`.

## Configuration
- Macro: `GPC1406_ARB_SELFCHECK_EN`.
- **Defined.** A behavioural reference sum is computed from the muxed bundle and compared with the `gpc1406_5` output on every grant. On a mismatch, `err` sets at that edge and stays set until `rst`.
- **Undefined.** No checker logic is compiled; `err` is tied to 0. Datapath timing is identical either way.

## Test plan
- **Single requester.** After reset, req0 presents src0=6'h2d, src2=4'ha, src3=0 → `req_ready`=0001 in that cycle. Next cycle: `out_valid`=1, `out_sum`=5'h0c, `out_id`=0.
- **Maximum sum.** req2 presents src0=6'h3f, src2=4'hf, src3=1 → `out_sum`=5'h1e, `out_id`=2. Also src0=6'h20, src2=4'h5, src3=1 → 5'h11.
- **Fairness.** All 4 requesters valid, `out_ready` held at 1 → grants 0,1,2,3,0,1 on consecutive edges, `out_valid` continuously 1, one result per cycle.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles with a pending result → `out_sum`/`out_id` stable and `req_ready`=0 throughout. When `out_ready`=1, the next grant goes to the index following the last grant.
- **Reset mid-operation.** Assert `rst` asynchronously while `out_valid`=1 and stalled → `out_valid`=0 immediately. After release, the first grant goes to the lowest valid index.
- **Self-check.** With `GPC1406_ARB_SELFCHECK_EN` defined, run 1000 random bundles → `err` stays 0. Force a counter output bit → `err`=1 and sticky until `rst`.

Source files
------------

// File: rtl/gpc1406_arb.sv
// Round-robin arbiter sharing one gpc1406_5 counter among NREQ requesters, with a registered valid/ready output.
// Optional macro GPC1406_ARB_SELFCHECK_EN adds a reference-sum checker driving the sticky err flag.

module gpc1406_5 (
    input  logic [5:0] src0,
    input  logic [3:0] src2,
    input  logic       src3,
    output logic [4:0] sum
);
    logic [2:0] cnt0;
    logic [2:0] cnt2;

    // Per-column popcounts, then weighted recombination into the 5-bit result.
    always_comb begin
        cnt0 = 3'(src0[0]) + 3'(src0[1]) + 3'(src0[2])
             + 3'(src0[3]) + 3'(src0[4]) + 3'(src0[5]);
        cnt2 = 3'(src2[0]) + 3'(src2[1]) + 3'(src2[2]) + 3'(src2[3]);
        sum  = 5'(cnt0) + {cnt2, 2'b00} + 5'({src3, 3'b000});
    end
endmodule

module gpc1406_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [6*NREQ-1:0]     req_src0,
    input  logic [4*NREQ-1:0]     req_src2,
    input  logic [NREQ-1:0]       req_src3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_sum,
    output logic [IDW-1:0]        out_id,
    output logic                  err
);
    localparam int unsigned SUMW = 5;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  ptr_next;
    logic            found;
    logic            grant;
    logic [5:0]      sel_src0;
    logic [3:0]      sel_src2;
    logic            sel_src3;
    logic [SUMW-1:0] cnt_sum;

    // Rotating priority search starting at ptr.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            logic [IDW-1:0] idx;
            idx = IDW'((int'(ptr) + k) % int'(NREQ));
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Grant only when the output register is free or draining this cycle; reset masks requests.
    always_comb begin
        grant     = found && (!out_valid || out_ready) && !rst;
        req_ready = grant ? (NREQ'(1) << grant_idx) : '0;
        ptr_next  = IDW'((int'(grant_idx) + 1) % int'(NREQ));
    end

    // NREQ:1 operand mux feeding the shared counter.
    always_comb begin
        sel_src0 = '0;
        sel_src2 = '0;
        sel_src3 = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (grant_idx == IDW'(k)) begin
                sel_src0 = req_src0[6*k +: 6];
                sel_src2 = req_src2[4*k +: 4];
                sel_src3 = req_src3[k];
            end
        end
    end

    gpc1406_5 u_gpc (
        .src0 (sel_src0),
        .src2 (sel_src2),
        .src3 (sel_src3),
        .sum  (cnt_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_sum   <= cnt_sum;
            out_id    <= grant_idx;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef GPC1406_ARB_SELFCHECK_EN
    logic [SUMW-1:0] ref_sum;

    // Bit-serial reference sum, structurally independent of the counter.
    always_comb begin
        ref_sum = '0;
        for (int i = 0; i < 6; i++) ref_sum = ref_sum + (sel_src0[i] ? SUMW'(1) : SUMW'(0));
        for (int i = 0; i < 4; i++) ref_sum = ref_sum + (sel_src2[i] ? SUMW'(4) : SUMW'(0));
        ref_sum = ref_sum + (sel_src3 ? SUMW'(8) : SUMW'(0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (grant && (ref_sum != cnt_sum)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gpc1406_arb.sv
// Directed bench for gpc1406_arb (NREQ=4): arithmetic, round-robin order, backpressure, reset and err behaviour.

module tb_gpc1406_arb;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [6*NREQ-1:0] req_src0 = '0;
    logic [4*NREQ-1:0] req_src2 = '0;
    logic [NREQ-1:0]   req_src3 = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [4:0]        out_sum;
    logic [IDW-1:0]    out_id;
    logic              err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    gpc1406_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src0  (req_src0),
        .req_src2  (req_src2),
        .req_src3  (req_src3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] s0, input logic [3:0] s2, input logic s3);
        req_src0[6*i +: 6] = s0;
        req_src2[4*i +: 4] = s2;
        req_src3[i]        = s3;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hf;
        #3;
        total_cnt++;
        if (req_ready !== 4'h0) $display("FAIL reset_ready: got %b expected 0000", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_sum !== 5'h00 || out_id !== 2'd0) $display("FAIL reset_data: got sum %h id %0d expected 00/0", out_sum, out_id);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err);
        else pass_cnt++;
        req_valid = '0;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_req(0, 6'h2d, 4'ha, 1'b0);
        req_valid = 4'b0001;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready);
        else pass_cnt++;
        tick();
        req_valid = '0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_sum !== 5'h0c || out_id !== 2'd0)
            $display("FAIL single_out: got v%b sum %h id %0d expected v1 0c 0", out_valid, out_sum, out_id);
        else pass_cnt++;
    endtask

    task automatic test_max_sum();
        set_req(2, 6'h3f, 4'hf, 1'b1);
        req_valid = 4'b0100;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL max_ready: got %b expected 0100", req_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_sum !== 5'h1e || out_id !== 2'd2)
            $display("FAIL max_out: got v%b sum %h id %0d expected v1 1e 2", out_valid, out_sum, out_id);
        else pass_cnt++;
        set_req(2, 6'h20, 4'h5, 1'b1);
        #1;
        total_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL mixed_ready: got %b expected 0100", req_ready);
        else pass_cnt++;
        tick();
        req_valid = '0;
        total_cnt++;
        if (out_sum !== 5'h11 || out_id !== 2'd2) $display("FAIL mixed_out: got sum %h id %0d expected 11 2", out_sum, out_id);
        else pass_cnt++;
    endtask

    task automatic test_fairness();
        logic [4:0] exp_sum [4] = '{5'h01, 5'h06, 5'h13, 5'h16};
        pulse_reset();
        set_req(0, 6'h01, 4'h0, 1'b0);
        set_req(1, 6'h03, 4'h1, 1'b0);
        set_req(2, 6'h07, 4'h3, 1'b1);
        set_req(3, 6'h3f, 4'hf, 1'b0);
        req_valid = 4'hf;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            logic [3:0] exp_ready;
            exp_ready = 4'b0001 << (k % 4);
            total_cnt++;
            if (req_ready !== exp_ready) $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_id !== 2'(k % 4) || out_sum !== exp_sum[k % 4])
                $display("FAIL rr_out[%0d]: got v%b id %0d sum %h expected v1 %0d %h",
                         k, out_valid, out_id, out_sum, k % 4, exp_sum[k % 4]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (req_ready !== 4'h0) $display("FAIL stall_ready[%0d]: got %b expected 0000", k, req_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_id !== 2'd1 || out_sum !== 5'h06)
                $display("FAIL stall_hold[%0d]: got v%b id %0d sum %h expected v1 1 06", k, out_valid, out_id, out_sum);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL resume_ready: got %b expected 0100", req_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_id !== 2'd2 || out_sum !== 5'h13) $display("FAIL resume_out: got id %0d sum %h expected 2 13", out_id, out_sum);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || req_ready !== 4'h0)
            $display("FAIL midrst: got v%b ready %b expected v0 0000", out_valid, req_ready);
        else pass_cnt++;
        rst = 1'b0;
        req_valid = 4'b1010;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL midrst_first: got %b expected 0010", req_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_sum !== 5'h06)
            $display("FAIL midrst_out: got v%b id %0d sum %h expected v1 1 06", out_valid, out_id, out_sum);
        else pass_cnt++;
    endtask

    task automatic test_single_active();
        out_ready = 1'b1;
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++;
            if (req_ready !== 4'b1000) $display("FAIL solo_ready[%0d]: got %b expected 1000", k, req_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_id !== 2'd3 || out_sum !== 5'h16)
                $display("FAIL solo_out[%0d]: got v%b id %0d sum %h expected v1 3 16", k, out_valid, out_id, out_sum);
            else pass_cnt++;
        end
        req_valid = '0;
        tick();
    endtask

`ifdef GPC1406_ARB_SELFCHECK_EN
    task automatic test_selfcheck();
        for (int k = 0; k < 1000; k++) begin
            req_valid = 4'($urandom);
            req_src0  = 24'($urandom);
            req_src2  = 16'($urandom);
            req_src3  = 4'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        total_cnt++;
        if (err !== 1'b0) $display("FAIL sc_random: got err %b expected 0", err);
        else pass_cnt++;
        out_ready = 1'b1;
        req_valid = 4'b0001;
        set_req(0, 6'h00, 4'h0, 1'b0);
        force dut.u_gpc.sum = 5'h1f;
        tick();
        release dut.u_gpc.sum;
        req_valid = '0;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL sc_detect: got err %b expected 1", err);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (err !== 1'b1) $display("FAIL sc_sticky: got err %b expected 1", err);
        else pass_cnt++;
        pulse_reset();
        total_cnt++;
        if (err !== 1'b0) $display("FAIL sc_clear: got err %b expected 0", err);
        else pass_cnt++;
    endtask
`else
    task automatic test_err_tied();
        total_cnt++;
        if (err !== 1'b0) $display("FAIL err_tied: got %b expected 0", err);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_single();
        test_max_sum();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_single_active();
`ifdef GPC1406_ARB_SELFCHECK_EN
        test_selfcheck();
`else
        test_err_tied();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
